// File: rtl/puf_cipher_pkg.sv
// Shared types and constants for the PUF-keyed character decoder.
// Holds the FSM state enum and the keystream LFSR definition.
package puf_cipher_pkg;

    typedef enum logic [1:0] {
        WAIT_KEY,
        GET_LO,
        GET_HI,
        EMIT
    } state_t;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    // Shift left, feedback is parity of bits 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] k);
        return {k[6:0], ^(k & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_keystream_lfsr.sv
// Keystream register: seeded from the PUF, stepped once per emitted char.
// An all-zero seed would lock the LFSR, so it is replaced on load.
module puf_keystream_lfsr
    import puf_cipher_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] key
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key <= 8'h01;
        end else if (load) begin
            key <= (seed == 8'h00) ? ZERO_SEED_SUB : seed;
        end else if (advance) begin
            key <= lfsr_next(key);
        end
    end

endmodule

// File: rtl/puf_cipher_decoder.sv
// Decodes 16-bit {check, cipher} pairs into plaintext bytes with an
// integrity flag and a saturating error counter.
module puf_cipher_decoder
    import puf_cipher_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_load,
    input  logic [7:0]       puf_response,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_char,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_count
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] key;
    logic [7:0] lo;
    logic [7:0] plain;
    logic [7:0] check;
    logic       in_fire;
    logic       out_fire;

    // Handshake signals depend only on registered state.
    assign in_ready  = (state == GET_LO) || (state == GET_HI);
    assign out_valid = (state == EMIT);

    // A key load overrides any handshake in the same cycle.
    assign in_fire  = in_valid && in_ready && !key_load;
    assign out_fire = out_valid && out_ready && !key_load;

    assign plain = lo ^ key;
    assign check = plain + key;

    puf_keystream_lfsr u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (key_load),
        .advance (out_fire),
        .seed    (puf_response),
        .key     (key)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_KEY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (key_load) begin
            state_nxt = GET_LO;
        end else begin
            unique case (state)
                WAIT_KEY: state_nxt = WAIT_KEY;
                GET_LO:   if (in_fire) state_nxt = GET_HI;
                GET_HI:   if (in_fire) state_nxt = EMIT;
                EMIT:     if (out_fire) state_nxt = GET_LO;
                default:  state_nxt = WAIT_KEY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lo       <= 8'h00;
            out_char <= 8'h00;
            out_err  <= 1'b0;
        end else if (key_load) begin
            lo <= 8'h00;
        end else if (in_fire && state == GET_LO) begin
            lo <= in_byte;
        end else if (in_fire && state == GET_HI) begin
            out_char <= plain;
            out_err  <= (check != in_byte);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (out_fire && out_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_puf_cipher_decoder.sv
// Directed bench for puf_cipher_decoder with a transaction-level model
// compared every cycle, plus literal checks that pin the model.
module tb_puf_cipher_decoder;

    logic       clock;
    logic       reset;
    logic       key_load;
    logic [7:0] puf_response;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_char;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_count;

    int tests = 0;
    int fails = 0;

    puf_cipher_decoder #(.CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_load     (key_load),
        .puf_response (puf_response),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_char     (out_char),
        .out_err      (out_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_count    (err_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int key_step(input int k);
        int fb;
        fb = ((k >> 7) ^ (k >> 5) ^ (k >> 4) ^ (k >> 3)) & 1;
        return ((k * 2) % 256) + fb;
    endfunction

    // Model: phase 0 = no key, 1 = want low, 2 = want high, 3 = holding char.
    int m_phase = 0;
    int m_key   = 1;
    int m_lo    = 0;
    int m_char  = 0;
    int m_err   = 0;
    int m_cnt   = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_key   <= 1;
            m_lo    <= 0;
            m_char  <= 0;
            m_err   <= 0;
            m_cnt   <= 0;
        end else if (key_load) begin
            m_key   <= (puf_response == 8'h00) ? 1 : int'(puf_response);
            m_phase <= 1;
            m_lo    <= 0;
        end else if (m_phase == 1 && in_valid) begin
            m_lo    <= int'(in_byte);
            m_phase <= 2;
        end else if (m_phase == 2 && in_valid) begin
            m_char  <= m_lo ^ m_key;
            m_err   <= (((m_lo ^ m_key) + m_key) % 256) != int'(in_byte) ? 1 : 0;
            m_phase <= 3;
        end else if (m_phase == 3 && out_ready) begin
            m_key   <= key_step(m_key);
            if (m_err == 1 && m_cnt < 255) m_cnt <= m_cnt + 1;
            m_phase <= 1;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("in_ready", int'(in_ready), (m_phase == 1 || m_phase == 2) ? 1 : 0);
            chk("out_valid", int'(out_valid), (m_phase == 3) ? 1 : 0);
            chk("err_count", int'(err_count), m_cnt);
            if (m_phase == 3) begin
                chk("out_char", int'(out_char), m_char);
                chk("out_err", int'(out_err), m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_key(input logic [7:0] s);
        key_load     = 1'b1;
        puf_response = s;
        tick();
        key_load     = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] lo_b, input logic [7:0] hi_b);
        in_valid = 1'b1;
        in_byte  = lo_b;
        tick();
        chk("no_early_valid", int'(out_valid), 0);
        in_byte  = hi_b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", int'(out_valid), 0);
    endtask

    initial begin
        reset        = 1'b1;
        key_load     = 1'b0;
        puf_response = 8'h00;
        in_byte      = 8'h00;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_char", int'(out_char), 0);
        chk("rst_err_count", int'(err_count), 0);
        reset = 1'b0;

        // Bytes offered before a key is loaded are ignored.
        in_valid = 1'b1;
        in_byte  = 8'h55;
        tick();
        tick();
        chk("wait_key_ready", int'(in_ready), 0);
        in_valid = 1'b0;

        load_key(8'h01);
        send_pair(8'h40, 8'h42);
        chk("c1_char", int'(out_char), 8'h41);
        chk("c1_err", int'(out_err), 0);
        chk("c1_valid", int'(out_valid), 1);
        accept();

        send_pair(8'h40, 8'h44);
        chk("c2_char", int'(out_char), 8'h42);
        chk("c2_err", int'(out_err), 0);
        accept();

        load_key(8'h01);
        send_pair(8'h40, 8'hFF);
        chk("c3_char", int'(out_char), 8'h41);
        chk("c3_err", int'(out_err), 1);
        accept();
        chk("c3_count", int'(err_count), 1);

        load_key(8'h00);
        send_pair(8'h40, 8'h42);
        chk("zero_seed_char", int'(out_char), 8'h41);
        chk("zero_seed_err", int'(out_err), 0);
        accept();

        load_key(8'h01);
        send_pair(8'h40, 8'h42);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_char", int'(out_char), 8'h41);
            chk("hold_ready", int'(in_ready), 0);
        end
        // Key load wins over a simultaneous accept.
        out_ready    = 1'b1;
        key_load     = 1'b1;
        puf_response = 8'h37;
        tick();
        key_load  = 1'b0;
        out_ready = 1'b0;
        chk("kl_valid", int'(out_valid), 0);
        chk("kl_ready", int'(in_ready), 1);
        chk("kl_count", int'(err_count), 1);
        send_pair(8'h10, 8'h5E);
        chk("k37_char", int'(out_char), 8'h27);
        chk("k37_err", int'(out_err), 0);
        accept();

        // Reset with only the low byte held.
        in_valid = 1'b1;
        in_byte  = 8'h11;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_char", int'(out_char), 0);
        chk("mid_rst_err", int'(out_err), 0);
        chk("mid_rst_count", int'(err_count), 0);
        tick();
        reset = 1'b0;

        in_valid = 1'b1;
        in_byte  = 8'h22;
        tick();
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", int'(out_valid), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
